// File: rtl/tick_controller_pkg.sv
// Shared encodings and reset divisors for the tick controller.
package tick_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ADJUST = 2'd3
  } state_t;

  localparam logic [31:0] DEF_DIV_1HZ  = 32'd100000000;
  localparam logic [31:0] DEF_DIV_2HZ  = 32'd50000000;
  localparam logic [31:0] DEF_DIV_FAST = 32'd400000;

  localparam logic [1:0] SEL_1HZ  = 2'd0;
  localparam logic [1:0] SEL_2HZ  = 2'd1;
  localparam logic [1:0] SEL_FAST = 2'd2;

  // A divisor of 0 or 1 would never produce an isolated pulse.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/tick_controller_tick_gen.sv
// Programmable modulo-div counter with a one-cycle tick on the last count.
module tick_gen
  import tick_controller_pkg::*;
#(
  parameter logic [31:0] DIV_RST = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [31:0] i_div,
  output logic        o_tick
);

  logic [31:0] r_div;
  logic [31:0] r_cnt;
  logic        w_last;

  assign w_last = (r_cnt == r_div - 32'd1);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= clamp_div(DIV_RST);
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= clamp_div(i_div);
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? 32'd0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/tick_controller.sv
// Run/pause/adjust controller gating three programmable tick generators.
module tick_controller
  import tick_controller_pkg::*;
#(
  parameter logic [31:0] DIV_1HZ  = DEF_DIV_1HZ,
  parameter logic [31:0] DIV_2HZ  = DEF_DIV_2HZ,
  parameter logic [31:0] DIV_FAST = DEF_DIV_FAST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        clr,
  input  logic        adj,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_div,
  output logic        cfg_ready,
  output logic        tick_1hz,
  output logic        tick_2hz,
  output logic        tick_fast,
  output logic        run_tick,
  output logic        blink,
  output logic [1:0]  state
);

  state_t     r_state;
  state_t     w_nxt;
  logic       r_blink;
  logic       w_accept;
  logic [2:0] w_load;
  logic       w_hold_now;
  logic       w_hold_nxt;

  assign cfg_ready = (r_state == ST_IDLE);
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_load[0] = w_accept && (cfg_sel == SEL_1HZ);
  assign w_load[1] = w_accept && (cfg_sel == SEL_2HZ);
  assign w_load[2] = w_accept && (cfg_sel == SEL_FAST);

  always_comb begin
    w_nxt = r_state;
    if (clr) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (adj) w_nxt = ST_ADJUST; else if (start) w_nxt = ST_RUN;
        ST_RUN:    if (pause) w_nxt = ST_PAUSE;
        ST_PAUSE:  if (adj) w_nxt = ST_ADJUST; else if (pause) w_nxt = ST_RUN;
        ST_ADJUST: if (!adj) w_nxt = ST_PAUSE;
        default:   w_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_hold_now = (r_state == ST_PAUSE) || (r_state == ST_ADJUST);
  assign w_hold_nxt = (w_nxt == ST_PAUSE) || (w_nxt == ST_ADJUST);

  // Blink is forced low on the edge that leaves PAUSE/ADJUST so it never leaks into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_blink <= w_hold_nxt ? (r_blink ^ (tick_2hz && w_hold_now)) : 1'b0;
    end
  end

  tick_gen #(.DIV_RST(DIV_1HZ)) u_tick_1hz (
    .clk(clk), .rst_n(rst_n), .i_en(r_state == ST_RUN), .i_clr(w_nxt == ST_IDLE),
    .i_load(w_load[0]), .i_div(cfg_div), .o_tick(tick_1hz)
  );

  tick_gen #(.DIV_RST(DIV_2HZ)) u_tick_2hz (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
    .i_load(w_load[1]), .i_div(cfg_div), .o_tick(tick_2hz)
  );

  tick_gen #(.DIV_RST(DIV_FAST)) u_tick_fast (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
    .i_load(w_load[2]), .i_div(cfg_div), .o_tick(tick_fast)
  );

  always_comb begin
    run_tick = 1'b0;
    case (r_state)
      ST_RUN:    run_tick = tick_1hz;
      ST_ADJUST: run_tick = tick_2hz;
      default:   run_tick = 1'b0;
    endcase
  end

  assign state = r_state;
  assign blink = r_blink;

endmodule

// File: tb/tb_tick_controller.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_tick_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, clr = 1'b0, adj = 1'b0, cfg_valid = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_div = 32'd0;
  logic        cfg_ready, tick_1hz, tick_2hz, tick_fast, run_tick, blink;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_controller #(.DIV_1HZ(32'd10), .DIV_2HZ(32'd5), .DIV_FAST(32'd2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clr(clr), .adj(adj),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_fast(tick_fast),
    .run_tick(run_tick), .blink(blink), .state(state)
  );

  // Reference model: state 0..3 = IDLE/RUN/PAUSE/ADJUST; index 0=1Hz, 1=2Hz, 2=fast.
  int          m_state;
  int unsigned m_cnt[3];
  int unsigned m_div[3];
  bit          m_blink;

  function automatic bit m_tick(input int i);
    return ((i != 0) || (m_state == 1)) && (m_cnt[i] == m_div[i] - 1);
  endfunction

  function automatic bit m_run();
    if (m_state == 1) return m_tick(0);
    if (m_state == 3) return m_tick(1);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_blink = 1'b0;
    m_div[0] = 10; m_div[1] = 5; m_div[2] = 2;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    int ns;
    bit acc, t2;
    acc = cfg_valid && (m_state == 0) && (cfg_sel != 2'd3);
    t2  = m_tick(1);
    ns  = m_state;
    if (clr) ns = 0;
    else if (adj && (m_state == 0 || m_state == 2)) ns = 3;
    else if (!adj && m_state == 3) ns = 2;
    else if (pause && m_state == 1) ns = 2;
    else if (pause && m_state == 2) ns = 1;
    else if (start && m_state == 0) ns = 1;
    for (int i = 0; i < 3; i++) begin
      if (acc && cfg_sel == i[1:0]) begin
        m_div[i] = (cfg_div < 2) ? 2 : cfg_div;
        m_cnt[i] = 0;
      end else if (i == 0 && ns == 0) begin
        m_cnt[i] = 0;
      end else if (i != 0 || m_state == 1) begin
        m_cnt[i] = (m_cnt[i] == m_div[i] - 1) ? 0 : m_cnt[i] + 1;
      end
    end
    m_blink = (ns >= 2) ? (m_blink ^ (t2 && m_state >= 2)) : 1'b0;
    m_state = ns;
  endtask

  // One clock: model follows the same edge, then one-cycle pulses are dropped.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    start = 1'b0; pause = 1'b0; clr = 1'b0; cfg_valid = 1'b0;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: return run_tick;
      1: return tick_fast;
      2: return tick_2hz;
      default: return tick_1hz;
    endcase
  endfunction

  // Steps until the chosen signal is high; 100 means the bound expired.
  task automatic wait_sig(input int which, output int n);
    n = 0;
    do begin step(); n++; end while (!sig(which) && n < 100);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; adj = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({state, tick_1hz, tick_2hz, tick_fast, run_tick, blink} !== 7'd0) begin
      errors++; $display("FAIL reset_outputs got %b expected 0", {state, tick_1hz, tick_2hz, tick_fast, run_tick, blink});
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b expected 1", cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    // The release cycle holds count 0, so the 5th cycle carries the first 2Hz tick.
    wait_sig(2, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL first_tick_2hz got %0d expected 4 edges", n); end
  endtask

  task automatic test_run();
    int n;
    start = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL first_run_tick got %0d expected 10", n); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL run_state got %0d expected 1", state); end
    wait_sig(0, n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL run_period got %0d expected 10", n); end
  endtask

  task automatic test_pause();
    int n, toggles, bad;
    bit prev;
    repeat (7) step();
    pause = 1'b1;
    step();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL pause_state got %0d expected 2", state); end
    toggles = 0; bad = 0; prev = blink;
    repeat (20) begin
      step();
      if (run_tick) bad++;
      if (blink != prev) toggles++;
      prev = blink;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL run_tick_in_pause got %0d expected 0", bad); end
    checks++;
    if (toggles !== 4) begin errors++; $display("FAIL blink_toggles got %0d expected 4", toggles); end
    pause = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL resume_latency got %0d expected 3", n); end
  endtask

  task automatic test_adjust();
    int n;
    pause = 1'b1;
    step();
    adj = 1'b1;
    step();
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL adjust_state got %0d expected 3", state); end
    wait_sig(0, n);
    wait_sig(0, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL adjust_period got %0d expected 5", n); end
    checks++;
    if (blink !== m_blink) begin errors++; $display("FAIL adjust_blink got %b expected %b", blink, m_blink); end
    adj = 1'b0;
    step();
    checks++;
    if ({state, run_tick} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL adjust_exit got state %0d run %b expected 2/0", state, run_tick);
    end
    clr = 1'b1;
    step();
  endtask

  task automatic test_cfg();
    int n;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready got %b expected 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 32'd4;
    step();
    start = 1'b1;
    wait_sig(0, n);
    wait_sig(0, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL cfg_period got %0d expected 4", n); end
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL run_cfg_ready got %b expected 0", cfg_ready); end
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 32'd7;
    wait_sig(0, n);
    wait_sig(0, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL run_write_ignored got %0d expected 4", n); end
    clr = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 32'd6; start = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL accept_with_start got %0d expected 6", n); end
    clr = 1'b1;
    step();
  endtask

  task automatic test_clamp();
    int n;
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = 32'd3;
    wait_sig(1, n);
    wait_sig(1, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL fast_div3 got %0d expected 3", n); end
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = 32'd0;
    wait_sig(1, n);
    wait_sig(1, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL fast_clamp got %0d expected 2", n); end
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = 32'd7;
    wait_sig(2, n);
    wait_sig(2, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL reserved_2hz got %0d expected 5", n); end
    wait_sig(1, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL reserved_fast got %0d expected 2", n); end
    start = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL reserved_1hz got %0d expected 6", n); end
  endtask

  task automatic test_clr_priority();
    int n;
    repeat (3) step();
    clr = 1'b1; pause = 1'b1; adj = 1'b1;
    step();
    adj = 1'b0;
    checks++;
    if ({state, run_tick} !== 3'd0) begin
      errors++; $display("FAIL clr_priority got state %0d run %b expected 0/0", state, run_tick);
    end
    start = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL clr_count_zero got %0d expected 6", n); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_sig(0, n);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, tick_1hz, tick_2hz, tick_fast, run_tick, blink, cfg_ready} !== 8'b00000001) begin
      errors++;
      $display("FAIL async_reset got %b expected 00000001", {state, tick_1hz, tick_2hz, tick_fast, run_tick, blink, cfg_ready});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    wait_sig(0, n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL div_after_reset got %0d expected 10", n); end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      pause     = ($urandom_range(0, 7) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) adj = ~adj;
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_div   = $urandom_range(0, 7);
      step();
      got = {state, tick_1hz, tick_2hz, tick_fast, run_tick, blink, cfg_ready};
      exp = {2'(m_state), m_tick(0), m_tick(1), m_tick(2), m_run(), m_blink, (m_state == 0)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle_%0d got %b expected %b", c, got, exp);
      end
    end
    adj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_adjust();
    test_cfg();
    test_clamp();
    test_clr_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
